mc_datapath: RTL and testbench

- Multi-cycle MIPS datapath executing R-type (add/sub/and/or/slt/nor), addi, lw, sw, beq and j.
- Driven cycle-by-cycle by the existing multi-cycle control FSM; returns the opcode field to it.
- Holds PC, IR, MDR, A, B and ALUOut, the register file, ALU and ALU decode.
- Drives one unified word-addressed instruction/data memory port.

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_regfile.sv | 41 ++++
 rtl/mc_datapath.sv | 175 +++++++++++++++++
 tb/tb_mc_datapath.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS datapath.
// Holds the control-field encodings (pc_src, alu_src_b, alu_op), the R-type
// funct codes, the opcode constants used by control, and the instruction layout.
package mc_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned INSTR_W  = 32;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    SRC_B_REG      = 2'b00,
    SRC_B_FOUR     = 2'b01,
    SRC_B_IMM      = 2'b10,
    SRC_B_IMM_SHL2 = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

  localparam logic [OP_W-1:0] OP_R_TYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW     = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW     = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
  localparam logic [OP_W-1:0] OP_J      = 6'b000010;

  // MIPS instruction word; I-type immediate is {rd, shamt, funct}, J target is [25:0].
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [4:0]         shamt;
    logic [FUNCT_W-1:0] funct;
  } instr_t;

endpackage

// File: rtl/mc_regfile.sv
// 32-entry register file for the multi-cycle datapath.
// Ports: clk, reset (async, active-high, clears all entries); three async read
// ports (a, b, dbg); one synchronous write port (we, waddr, wdata).
// Register 0 is never written and always reads zero.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] raddr_dbg,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_dbg,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: async clear, write suppressed for r0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[REG_AW'(i)] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads are combinational; r0 forced to zero regardless of contents.
  assign rdata_a   = (raddr_a   == '0) ? '0 : regs[raddr_a];
  assign rdata_b   = (raddr_b   == '0) ? '0 : regs[raddr_b];
  assign rdata_dbg = (raddr_dbg == '0) ? '0 : regs[raddr_dbg];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath (R-type, addi, lw, sw, beq, j).
// Sequenced cycle by cycle by the external control FSM; holds PC, IR, MDR,
// A, B, ALUOut, the register file and the ALU with its funct decode.
// Ports:
//   clk, reset          clock, async active-high reset
//   pc_src .. alu_op    control word from the control FSM
//   op                  IR opcode field back to control
//   mem_addr/wdata/we   unified word-addressed memory port
//   mem_rdata           combinational memory read data
//   dbg_reg_addr/data   async debug read of the register file
//   dbg_pc              current PC
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       MEM_AW   = 8,
  parameter logic [DATA_W-1:0] PC_RESET = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        pc_src,
  input  logic              alu_src_a,
  input  logic [1:0]        alu_src_b,
  input  logic              iord,
  input  logic              mem_to_reg,
  input  logic              ir_write,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic              reg_dst,
  input  logic              pc_write_cond,
  input  logic              pc_write,
  input  logic [1:0]        alu_op,
  output logic [OP_W-1:0]   op,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [REG_AW-1:0] dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data,
  output logic [DATA_W-1:0] dbg_pc
);

  localparam int unsigned IMM_W = 16;

  logic [DATA_W-1:0] pc_q;
  instr_t            ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_out_q;

  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_shl2;
  logic [DATA_W-1:0] jump_target;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic              zero;
  logic              pc_en;
  logic [DATA_W-1:0] pc_next;

  // Immediate and jump-target formation from IR.
  assign imm         = {ir_q.rd, ir_q.shamt, ir_q.funct};
  assign imm_sext    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_shl2    = {imm_sext[DATA_W-3:0], 2'b00};
  assign jump_target = {pc_q[DATA_W-1:DATA_W-4], ir_q.rs, ir_q.rt, ir_q.rd,
                        ir_q.shamt, ir_q.funct, 2'b00};

  // ALU operand muxes.
  always_comb begin
    src_a = alu_src_a ? a_q : pc_q;
    src_b = '0;
    case (alu_src_b)
      SRC_B_REG:      src_b = b_q;
      SRC_B_FOUR:     src_b = DATA_W'(4);
      SRC_B_IMM:      src_b = imm_sext;
      SRC_B_IMM_SHL2: src_b = imm_shl2;
      default:        src_b = '0;
    endcase
  end

  // ALU with inline funct decode; undefined functs and alu_op 11 yield zero.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_OP_ADD: alu_result = src_a + src_b;
      ALU_OP_SUB: alu_result = src_a - src_b;
      ALU_OP_FUNCT: begin
        case (ir_q.funct)
          FUNCT_ADD: alu_result = src_a + src_b;
          FUNCT_SUB: alu_result = src_a - src_b;
          FUNCT_AND: alu_result = src_a & src_b;
          FUNCT_OR:  alu_result = src_a | src_b;
          FUNCT_SLT: alu_result = DATA_W'($signed(src_a) < $signed(src_b));
          FUNCT_NOR: alu_result = ~(src_a | src_b);
          default:   alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // PC update; hold encoding keeps PC even when a write is enabled.
  assign pc_en = pc_write | (pc_write_cond & zero);

  always_comb begin
    pc_next = pc_q;
    case (pc_src)
      PC_SRC_ALU:    pc_next = alu_result;
      PC_SRC_ALUOUT: pc_next = alu_out_q;
      PC_SRC_JUMP:   pc_next = jump_target;
      PC_SRC_HOLD:   pc_next = pc_q;
      default:       pc_next = pc_q;
    endcase
  end

  // Architectural and inter-cycle registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      mdr_q     <= mem_rdata;
      a_q       <= rf_rdata_a;
      b_q       <= rf_rdata_b;
      alu_out_q <= alu_result;
      if (ir_write) begin
        ir_q <= mem_rdata;
      end
      if (pc_en) begin
        pc_q <= pc_next;
      end
    end
  end

  // Writeback selection uses the IR/MDR/ALUOut values present before the edge.
  assign rf_waddr = reg_dst ? ir_q.rd : ir_q.rt;
  assign rf_wdata = mem_to_reg ? mdr_q : alu_out_q;

  mc_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .raddr_a   (ir_q.rs),
    .raddr_b   (ir_q.rt),
    .raddr_dbg (dbg_reg_addr),
    .rdata_a   (rf_rdata_a),
    .rdata_b   (rf_rdata_b),
    .rdata_dbg (dbg_reg_data),
    .we        (reg_write),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata)
  );

  // Memory port; byte-offset bits of the address are dropped.
  assign mem_addr  = iord ? alu_out_q[MEM_AW+1:2] : pc_q[MEM_AW+1:2];
  assign mem_wdata = b_q;
  assign mem_we    = mem_write;
  assign op        = ir_q.op;
  assign dbg_pc    = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: plays a control-word program against
// the datapath, with hand-supplied memory read data, and checks the results.
module tb_mc_datapath;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       reg_dst;
    logic       pc_write_cond;
    logic       pc_write;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct {
    string       name;
    ctrl_t       c;
    logic [31:0] rdata;
    logic [4:0]  dbg;
    logic [5:0]  mask;
    logic [31:0] e_pc;
    logic [5:0]  e_op;
    logic [7:0]  e_maddr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_dbg;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [1:0]  aop;
    logic [31:0] res;
  } alu_vec_t;

  localparam logic [5:0] M_PC = 6'd1, M_OP = 6'd2, M_MA = 6'd4,
                         M_WE = 6'd8, M_WD = 6'd16, M_DBG = 6'd32;

  logic        clk = 1'b0;
  logic        reset;
  ctrl_t       ctl;
  logic [5:0]  op;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [31:0] dbg_pc;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t     vecs[$];
  vec_t     exp_q[$];
  alu_vec_t alu_tab[$];
  logic [31:0] pc_m;

  always #5 clk = ~clk;

  mc_datapath dut (
    .clk           (clk),
    .reset         (reset),
    .pc_src        (ctl.pc_src),
    .alu_src_a     (ctl.alu_src_a),
    .alu_src_b     (ctl.alu_src_b),
    .iord          (ctl.iord),
    .mem_to_reg    (ctl.mem_to_reg),
    .ir_write      (ctl.ir_write),
    .reg_write     (ctl.reg_write),
    .mem_write     (ctl.mem_write),
    .reg_dst       (ctl.reg_dst),
    .pc_write_cond (ctl.pc_write_cond),
    .pc_write      (ctl.pc_write),
    .alu_op        (ctl.alu_op),
    .op            (op),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .dbg_reg_addr  (dbg_reg_addr),
    .dbg_reg_data  (dbg_reg_data),
    .dbg_pc        (dbg_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '0;
    c.pc_src = 2'b11;
    return c;
  endfunction

  task automatic add_vec(input string name, input ctrl_t c, input logic [31:0] rdata,
                         input logic [4:0] dbg, input logic [5:0] mask,
                         input logic [31:0] e_pc, input logic [5:0] e_op,
                         input logic [7:0] e_maddr, input logic e_we,
                         input logic [31:0] e_wdata, input logic [31:0] e_dbg);
    vec_t v;
    v.name = name; v.c = c; v.rdata = rdata; v.dbg = dbg; v.mask = mask;
    v.e_pc = e_pc; v.e_op = e_op; v.e_maddr = e_maddr; v.e_we = e_we;
    v.e_wdata = e_wdata; v.e_dbg = e_dbg;
    vecs.push_back(v);
  endtask

  function automatic ctrl_t fetch_ctl();
    ctrl_t c;
    c = idle();
    c.pc_src = 2'b00; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1;
    return c;
  endfunction

  // Fetch: PC advances by 4 and op reflects the fetched word.
  task automatic fetch(input string name, input logic [31:0] instr);
    logic [31:0] npc;
    npc  = pc_m + 32'd4;
    pc_m = npc;
    add_vec({name, "_fetch"}, fetch_ctl(), instr, 5'd0, M_PC | M_OP | M_MA,
            npc, instr[31:26], npc[9:2], 1'b0, 32'd0, 32'd0);
  endtask

  task automatic decode(input string name);
    ctrl_t c;
    c = idle(); c.alu_src_b = 2'b11;
    add_vec({name, "_decode"}, c, 32'd0, 5'd0, 6'd0, 0, 0, 0, 0, 0, 0);
  endtask

  // Full addi: writeback shows the new value; B captured on that edge is pre-write.
  task automatic addi_prog(input string name, input logic [31:0] instr,
                           input logic [4:0] rt, input logic [31:0] val);
    ctrl_t c;
    fetch(name, instr);
    decode(name);
    c = idle(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    add_vec({name, "_exec"}, c, 32'd0, 5'd0, 6'd0, 0, 0, 0, 0, 0, 0);
    c = idle(); c.reg_write = 1'b1;
    add_vec({name, "_wb"}, c, 32'd0, rt, M_DBG | M_WD, 0, 0, 0, 0, 32'd0, val);
    add_vec({name, "_bcap"}, idle(), 32'd0, rt, M_WD, 0, 0, 0, 0, val, 0);
  endtask

  task automatic rtype_prog(input string name, input logic [31:0] instr,
                            input logic [1:0] aop, input logic [31:0] res);
    ctrl_t c;
    fetch(name, instr);
    decode(name);
    c = idle(); c.alu_src_a = 1'b1; c.alu_op = aop;
    add_vec({name, "_exec"}, c, 32'd0, 5'd0, 6'd0, 0, 0, 0, 0, 0, 0);
    c = idle(); c.reg_write = 1'b1; c.reg_dst = 1'b1;
    add_vec({name, "_wb"}, c, 32'd0, 5'd14, M_DBG, 0, 0, 0, 0, 0, res);
  endtask

  initial begin
    ctrl_t c;
    vec_t  e;
    reset        = 1'b1;
    ctl          = idle();
    mem_rdata    = 32'd0;
    dbg_reg_addr = 5'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", dbg_pc, 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    for (int r = 0; r < 32; r += 8) begin
      dbg_reg_addr = 5'(r + 1);
      #1;
      chk("rst_rf", dbg_reg_data, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Program.
    pc_m = 32'h0;
    addi_prog("addi8", 32'h20080005, 5'd8, 32'd5);
    addi_prog("addi9", 32'h20090040, 5'd9, 32'h40);

    fetch("sw", 32'hAD280004);
    decode("sw");
    c = idle(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    add_vec("sw_exec", c, 32'd0, 5'd0, 6'd0, 0, 0, 0, 0, 0, 0);
    c.iord = 1'b1; c.mem_write = 1'b1;
    add_vec("sw_mem", c, 32'd0, 5'd0, M_MA | M_WE | M_WD, 0, 0, 8'd17, 1'b1, 32'd5, 0);

    fetch("lw", 32'h8D2A0004);
    decode("lw");
    c = idle(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    add_vec("lw_exec", c, 32'd0, 5'd0, 6'd0, 0, 0, 0, 0, 0, 0);
    c.iord = 1'b1;
    add_vec("lw_mem", c, 32'd5, 5'd0, M_MA | M_WE, 0, 0, 8'd17, 1'b0, 0, 0);
    c = idle(); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
    add_vec("lw_wb", c, 32'd0, 5'd10, M_DBG, 0, 0, 0, 0, 0, 32'd5);

    addi_prog("addi11", 32'h200B0007, 5'd11, 32'd7);
    addi_prog("addi12", 32'h200C0007, 5'd12, 32'd7);
    addi_prog("addi13", 32'h200D0006, 5'd13, 32'd6);
    addi_prog("addi15", 32'h200FFFFF, 5'd15, 32'hFFFFFFFF);

    // beq taken: target = PC(after fetch) + 3*4.
    fetch("beq_t", 32'h116C0003);
    decode("beq_t");
    c = idle(); c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write_cond = 1'b1;
    pc_m = pc_m + 32'd12;
    add_vec("beq_taken", c, 32'd0, 5'd0, M_PC, pc_m, 0, 0, 0, 0, 0);

    fetch("beq_n", 32'h116D0003);
    decode("beq_n");
    add_vec("beq_not_taken", c, 32'd0, 5'd0, M_PC, pc_m, 0, 0, 0, 0, 0);

    c = idle(); c.pc_write = 1'b1;
    add_vec("pc_hold", c, 32'd0, 5'd0, M_PC, pc_m, 0, 0, 0, 0, 0);

    fetch("j", 32'h08000010);
    c = idle(); c.pc_src = 2'b10; c.pc_write = 1'b1;
    pc_m = 32'h40;
    add_vec("jump", c, 32'd0, 5'd0, M_PC, pc_m, 0, 0, 0, 0, 0);

    addi_prog("addi_r0", 32'h2000FFFF, 5'd0, 32'd0);

    // R-type ALU table; rf[11]=7, rf[13]=6, rf[15]=-1, rf[8]=5; rd = 14.
    alu_tab.push_back('{"add",      5'd13, 5'd11, 6'h20, 2'b10, 32'd13});
    alu_tab.push_back('{"sub",      5'd13, 5'd11, 6'h22, 2'b10, 32'hFFFFFFFF});
    alu_tab.push_back('{"and",      5'd13, 5'd11, 6'h24, 2'b10, 32'd6});
    alu_tab.push_back('{"or",       5'd13, 5'd11, 6'h25, 2'b10, 32'd7});
    alu_tab.push_back('{"nor",      5'd13, 5'd11, 6'h27, 2'b10, 32'hFFFFFFF8});
    alu_tab.push_back('{"slt_neg",  5'd15, 5'd11, 6'h2A, 2'b10, 32'd1});
    alu_tab.push_back('{"slt_pos",  5'd11, 5'd15, 6'h2A, 2'b10, 32'd0});
    alu_tab.push_back('{"slt_lt",   5'd13, 5'd11, 6'h2A, 2'b10, 32'd1});
    alu_tab.push_back('{"bad_fn",   5'd13, 5'd11, 6'h21, 2'b10, 32'd0});
    alu_tab.push_back('{"aop_add",  5'd13, 5'd11, 6'h22, 2'b00, 32'd13});
    alu_tab.push_back('{"aop_sub",  5'd13, 5'd11, 6'h20, 2'b01, 32'hFFFFFFFF});
    alu_tab.push_back('{"aop_11",   5'd13, 5'd11, 6'h20, 2'b11, 32'd0});
    alu_tab.push_back('{"add_wrap", 5'd15, 5'd8,  6'h20, 2'b10, 32'd4});
    foreach (alu_tab[i]) begin
      rtype_prog(alu_tab[i].name,
                 {6'b000000, alu_tab[i].rs, alu_tab[i].rt, 5'd14, 5'd0, alu_tab[i].funct},
                 alu_tab[i].aop, alu_tab[i].res);
    end

    // Writeback overlapped with the next fetch: write uses the old IR's rt.
    fetch("addi16", 32'h20100009);
    decode("addi16");
    c = idle(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    add_vec("addi16_exec", c, 32'd0, 5'd0, 6'd0, 0, 0, 0, 0, 0, 0);
    c = fetch_ctl(); c.reg_write = 1'b1;
    add_vec("wb_with_fetch", c, 32'h20110003, 5'd16, M_PC | M_OP | M_DBG,
            pc_m + 32'd4, 6'b001000, 0, 0, 0, 32'd9);
    add_vec("wb_fetch_rt17", idle(), 32'd0, 5'd17, M_DBG, 0, 0, 0, 0, 0, 32'd0);

    // Apply vectors; expected record queued at drive time, checked after the edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      ctl          = vecs[i].c;
      mem_rdata    = vecs[i].rdata;
      dbg_reg_addr = vecs[i].dbg;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e.mask[0]) chk({e.name, "_pc"},    dbg_pc,            e.e_pc);
      if (e.mask[1]) chk({e.name, "_op"},    32'(op),           32'(e.e_op));
      if (e.mask[2]) chk({e.name, "_maddr"}, 32'(mem_addr),     32'(e.e_maddr));
      if (e.mask[3]) chk({e.name, "_we"},    32'(mem_we),       32'(e.e_we));
      if (e.mask[4]) chk({e.name, "_wdata"}, mem_wdata,         e.e_wdata);
      if (e.mask[5]) chk({e.name, "_dbg"},   dbg_reg_data,      e.e_dbg);
    end

    // Reset mid-instruction with a register write pending.
    @(negedge clk);
    c = idle(); c.reg_write = 1'b1; c.reg_dst = 1'b1;
    ctl          = c;
    dbg_reg_addr = 5'd8;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_pc", dbg_pc, 32'h0);
    chk("midrst_op", 32'(op), 32'h0);
    chk("midrst_wdata", mem_wdata, 32'h0);
    chk("midrst_rf8", dbg_reg_data, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_rf8_edge", dbg_reg_data, 32'h0);
    @(negedge clk);
    reset        = 1'b0;
    ctl          = idle();
    dbg_reg_addr = 5'd14;
    @(posedge clk);
    #1;
    chk("postrst_rf14", dbg_reg_data, 32'h0);
    chk("postrst_pc", dbg_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
